// File: rtl/game_timer_display.sv
// HUD round countdown timer: M:SS BCD count ticked from a clk prescaler, drawn as 7-segment pixel art.
// Optional build macro TIMER_BLINK_EN blinks the digits at ~4 Hz while the warning is active in RUN.
module game_timer_display #(
  parameter int          CLK_FREQ   = 31_500_000,
  parameter int          START_SEC  = 180,
  parameter logic [10:0] TOP_X      = 11'd16,
  parameter logic [10:0] TOP_Y      = 11'd8,
  parameter logic [7:0]  COLOR      = 8'hFF,
  parameter logic [7:0]  WARN_COLOR = 8'hE0,
  parameter int          WARN_SEC   = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        start,
  input  logic        pause,
  input  logic        addTime,
  output logic        timerDR,
  output logic [7:0]  timerRGB,
  output logic        expired,
  output logic        warning
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam int             PW        = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0]  PRE_LAST  = PW'(CLK_FREQ - 1);
  localparam logic [3:0]     START_MIN = 4'(START_SEC / 60);
  localparam logic [3:0]     START_TEN = 4'((START_SEC % 60) / 10);
  localparam logic [3:0]     START_ONE = 4'(START_SEC % 10);

  state_t        state, state_next;
  logic [PW-1:0] prescaler;
  logic [3:0]    dig_min, dig_ten, dig_one;
  logic [3:0]    min_next, ten_next, one_next;
  logic          pending;
  logic          wrap, add_en, dec_en, dec_zero;
  logic [9:0]    total_sec;

  assign wrap     = (state == RUN) && (prescaler == PRE_LAST);
  assign add_en   = addTime && !start && ((state == RUN) || (state == PAUSED));
  // A tick that collides with addTime is deferred through pending, so dec_en excludes add_en.
  assign dec_en   = (state == RUN) && !start && !add_en && (wrap || pending);
  assign dec_zero = dec_en && (dig_min == 4'd0) && (dig_ten == 4'd0) && (dig_one == 4'd1);

  assign total_sec = 10'(dig_min) * 10'd60 + 10'(dig_ten) * 10'd10 + 10'(dig_one);
  assign warning   = (total_sec != 10'd0) && (total_sec <= 10'(WARN_SEC));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (dec_zero)   state_next = EXPIRED;
          else if (pause) state_next = PAUSED;
        end
        PAUSED:  if (!pause) state_next = RUN;
        default: state_next = state;
      endcase
    end
  end

  always_comb begin
    min_next = dig_min;
    ten_next = dig_ten;
    one_next = dig_one;
    if (add_en) begin
      if ((dig_min == 4'd9) && (dig_ten == 4'd5)) begin
        ten_next = 4'd5;
        one_next = 4'd9;
      end else if (dig_ten == 4'd5) begin
        ten_next = 4'd0;
        min_next = dig_min + 4'd1;
      end else begin
        ten_next = dig_ten + 4'd1;
      end
    end else if (dec_en) begin
      if (dig_one != 4'd0) begin
        one_next = dig_one - 4'd1;
      end else begin
        one_next = 4'd9;
        if (dig_ten != 4'd0) begin
          ten_next = dig_ten - 4'd1;
        end else begin
          ten_next = 4'd5;
          min_next = dig_min - 4'd1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset || start) begin
      dig_min   <= START_MIN;
      dig_ten   <= START_TEN;
      dig_one   <= START_ONE;
      prescaler <= '0;
      pending   <= 1'b0;
      expired   <= 1'b0;
    end else begin
      dig_min <= min_next;
      dig_ten <= ten_next;
      dig_one <= one_next;
      expired <= dec_zero;
      if (state == RUN) begin
        if (wrap || dec_zero) prescaler <= '0;
        else                  prescaler <= prescaler + PW'(1);
      end
      if (add_en)      pending <= pending | wrap;
      else if (dec_en) pending <= 1'b0;
    end
  end

  // Segment mask bit order is {g,f,e,d,c,b,a}; coordinates are local to a 16x32 cell.
  function automatic logic seg_hit(input logic [3:0] d, input logic [3:0] x, input logic [4:0] y);
    logic [6:0] s;
    logic       mid_x, left, right, upper, lower;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    mid_x = (x >= 4'd2) && (x <= 4'd13);
    left  = (x <= 4'd3);
    right = (x >= 4'd12);
    upper = (y >= 5'd2) && (y <= 5'd15);
    lower = (y >= 5'd16) && (y <= 5'd29);
    return (s[0] && mid_x && (y <= 5'd3))
        || (s[6] && mid_x && (y >= 5'd14) && (y <= 5'd17))
        || (s[3] && mid_x && (y >= 5'd28))
        || (s[5] && left  && upper)
        || (s[1] && right && upper)
        || (s[4] && left  && lower)
        || (s[2] && right && lower);
  endfunction

  logic [10:0] rel_x, rel_y;
  logic        in_box, is_colon, colon_hit, blank, hit;
  logic [3:0]  cell_digit, cx;
  logic [4:0]  cy;
  logic [7:0]  color;

  assign rel_x  = pixelX - TOP_X;
  assign rel_y  = pixelY - TOP_Y;
  assign in_box = (pixelX >= TOP_X) && (pixelY >= TOP_Y) && (rel_x < 11'd56) && (rel_y < 11'd32);
  assign cy     = rel_y[4:0];

  always_comb begin
    cell_digit = 4'd0;
    cx         = 4'd0;
    is_colon   = 1'b0;
    if (rel_x < 11'd16) begin
      cell_digit = dig_min;
      cx         = rel_x[3:0];
    end else if (rel_x < 11'd24) begin
      is_colon = 1'b1;
      cx       = 4'(rel_x - 11'd16);
    end else if (rel_x < 11'd40) begin
      cell_digit = dig_ten;
      cx         = 4'(rel_x - 11'd24);
    end else begin
      cell_digit = dig_one;
      cx         = 4'(rel_x - 11'd40);
    end
  end

  assign colon_hit = (cx >= 4'd2) && (cx <= 4'd5)
                  && (((cy >= 5'd8) && (cy <= 5'd11)) || ((cy >= 5'd20) && (cy <= 5'd23)));

`ifdef TIMER_BLINK_EN
  logic [3:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (reset)             frame_cnt <= 4'd0;
    else if (startOfFrame) frame_cnt <= frame_cnt + 4'd1;
  end

  assign blank = warning && (state == RUN) && frame_cnt[3];
`else
  logic unused_sof;
  assign unused_sof = startOfFrame;
  assign blank      = 1'b0;
`endif

  assign hit   = in_box && (is_colon ? colon_hit : (!blank && seg_hit(cell_digit, cx, cy)));
  assign color = warning ? WARN_COLOR : COLOR;

  always_ff @(posedge clk) begin
    if (reset) begin
      timerDR  <= 1'b0;
      timerRGB <= 8'h00;
    end else begin
      timerDR  <= hit;
      timerRGB <= hit ? color : 8'h00;
    end
  end

endmodule

// File: tb/tb_game_timer_display.sv
// Directed bench for game_timer_display: countdown, pause, addTime/tick collision, rendering, reset, saturation.
module tb_game_timer_display;

  localparam logic [10:0] TX     = 11'd16;
  localparam logic [10:0] TY     = 11'd8;
  localparam logic [7:0]  C_NORM = 8'hFF;
  localparam logic [7:0]  C_WARN = 8'hE0;

  logic        clk = 1'b0, reset = 1'b1, sof = 1'b0;
  logic        start = 1'b0, pause = 1'b0, add = 1'b0;
  logic        start2 = 1'b0, add2 = 1'b0;
  logic [10:0] px = 11'd0, py = 11'd0;
  logic        dr, expired, warning;
  logic [7:0]  rgb;
  logic        dr2, expired2, warning2;
  logic [7:0]  rgb2;
  logic [11:0] digs, digs2;
  logic [1:0]  st;
  int          vectors = 0;
  int          miscompares = 0;

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic        hit;
  } pix_t;

  always #5 clk = ~clk;

  game_timer_display #(
    .CLK_FREQ(10), .START_SEC(12), .TOP_X(TX), .TOP_Y(TY),
    .COLOR(C_NORM), .WARN_COLOR(C_WARN), .WARN_SEC(10)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(sof), .pixelX(px), .pixelY(py),
    .start(start), .pause(pause), .addTime(add),
    .timerDR(dr), .timerRGB(rgb), .expired(expired), .warning(warning)
  );

  game_timer_display #(
    .CLK_FREQ(10), .START_SEC(599), .TOP_X(TX), .TOP_Y(TY),
    .COLOR(C_NORM), .WARN_COLOR(C_WARN), .WARN_SEC(10)
  ) dut599 (
    .clk(clk), .reset(reset), .startOfFrame(sof), .pixelX(px), .pixelY(py),
    .start(start2), .pause(1'b0), .addTime(add2),
    .timerDR(dr2), .timerRGB(rgb2), .expired(expired2), .warning(warning2)
  );

  assign digs  = {dut.dig_min, dut.dig_ten, dut.dig_one};
  assign digs2 = {dut599.dig_min, dut599.dig_ten, dut599.dig_one};
  assign st    = dut.state;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(3);
    vectors++; if (digs !== 12'h012) begin miscompares++; $display("FAIL reset_digits: got %h want 012", digs); end
    vectors++; if (st !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", st); end
    vectors++; if ({dr, rgb, expired, warning} !== 11'd0) begin miscompares++;
      $display("FAIL reset_outputs: dr=%b rgb=%h exp=%b warn=%b want all 0", dr, rgb, expired, warning); end
    vectors++; if (digs2 !== 12'h959) begin miscompares++; $display("FAIL reset_digits_599: got %h want 959", digs2); end
    reset = 1'b0;
    cyc(12);
    vectors++; if (digs !== 12'h012 || st !== 2'd0) begin miscompares++;
      $display("FAIL idle_holds: digits %h state %0d want 012 / 0", digs, st); end
  endtask

  task automatic test_countdown();
    start = 1'b1; cyc(1); start = 1'b0;
    vectors++; if (digs !== 12'h012 || st !== 2'd1 || warning !== 1'b0) begin miscompares++;
      $display("FAIL start_run: digits %h state %0d warn %b want 012/1/0", digs, st, warning); end
    cyc(9);
    vectors++; if (digs !== 12'h012) begin miscompares++; $display("FAIL before_first_tick: got %h want 012", digs); end
    cyc(1);
    vectors++; if (digs !== 12'h011 || warning !== 1'b0) begin miscompares++;
      $display("FAIL tick_0_11: digits %h warn %b want 011/0", digs, warning); end
    cyc(10);
    vectors++; if (digs !== 12'h010 || warning !== 1'b1) begin miscompares++;
      $display("FAIL tick_0_10: digits %h warn %b want 010/1", digs, warning); end
    cyc(99);
    vectors++; if (digs !== 12'h001 || warning !== 1'b1 || expired !== 1'b0) begin miscompares++;
      $display("FAIL at_0_01: digits %h warn %b exp %b want 001/1/0", digs, warning, expired); end
    cyc(1);
    vectors++; if (digs !== 12'h000 || expired !== 1'b1 || st !== 2'd3 || warning !== 1'b0) begin miscompares++;
      $display("FAIL expiry: digits %h exp %b state %0d warn %b want 000/1/3/0", digs, expired, st, warning); end
    add = 1'b1; cyc(1); add = 1'b0;
    vectors++; if (expired !== 1'b0 || digs !== 12'h000 || st !== 2'd3) begin miscompares++;
      $display("FAIL expired_add_ignored: exp %b digits %h state %0d want 0/000/3", expired, digs, st); end
    cyc(20);
    vectors++; if (expired !== 1'b0 || digs !== 12'h000) begin miscompares++;
      $display("FAIL expired_hold: exp %b digits %h want 0/000", expired, digs); end
  endtask

  task automatic test_pause();
    start = 1'b1; cyc(1); start = 1'b0;
    vectors++; if (digs !== 12'h012 || st !== 2'd1) begin miscompares++;
      $display("FAIL restart_from_expired: digits %h state %0d want 012/1", digs, st); end
    cyc(4); pause = 1'b1;
    cyc(34);
    vectors++; if (digs !== 12'h012 || st !== 2'd2) begin miscompares++;
      $display("FAIL paused_frozen: digits %h state %0d want 012/2", digs, st); end
    cyc(1); pause = 1'b0;
    cyc(1);
    vectors++; if (st !== 2'd1) begin miscompares++; $display("FAIL resume_state: got %0d want 1", st); end
    cyc(4);
    vectors++; if (digs !== 12'h012) begin miscompares++; $display("FAIL resume_before_tick: got %h want 012", digs); end
    cyc(1);
    vectors++; if (digs !== 12'h011) begin miscompares++; $display("FAIL resume_tick: got %h want 011", digs); end
  endtask

  task automatic test_add_tick();
    cyc(39);
    vectors++; if (digs !== 12'h008 || warning !== 1'b1) begin miscompares++;
      $display("FAIL pre_add_0_08: digits %h warn %b want 008/1", digs, warning); end
    add = 1'b1; cyc(1); add = 1'b0;
    vectors++; if (digs !== 12'h018 || warning !== 1'b0 || st !== 2'd1) begin miscompares++;
      $display("FAIL add_on_wrap: digits %h warn %b state %0d want 018/0/1", digs, warning, st); end
    cyc(1);
    vectors++; if (digs !== 12'h017) begin miscompares++; $display("FAIL pending_tick: got %h want 017", digs); end
    cyc(8);
    vectors++; if (digs !== 12'h017) begin miscompares++; $display("FAIL after_pending_hold: got %h want 017", digs); end
    cyc(1);
    vectors++; if (digs !== 12'h016) begin miscompares++; $display("FAIL next_regular_tick: got %h want 016", digs); end
  endtask

  task automatic test_render();
    pix_t tab[13];
    logic prev;
    tab[0]  = '{TX + 11'd2,  TY + 11'd1,  1'b0};
    tab[1]  = '{TX + 11'd44, TY + 11'd1,  1'b1};
    tab[2]  = '{TX + 11'd26, TY + 11'd1,  1'b0};
    tab[3]  = '{TX + 11'd37, TY + 11'd5,  1'b1};
    tab[4]  = '{TX + 11'd19, TY + 11'd9,  1'b1};
    tab[5]  = '{TX + 11'd19, TY + 11'd14, 1'b0};
    tab[6]  = '{TX + 11'd47, TY + 11'd15, 1'b1};
    tab[7]  = '{TX + 11'd53, TY + 11'd20, 1'b0};
    tab[8]  = '{TX + 11'd41, TY + 11'd20, 1'b1};
    tab[9]  = '{TX + 11'd56, TY + 11'd1,  1'b0};
    tab[10] = '{TX - 11'd1,  TY + 11'd1,  1'b0};
    tab[11] = '{TX + 11'd14, TY + 11'd5,  1'b1};
    tab[12] = '{TX + 11'd14, TY + 11'd32, 1'b0};
    pause = 1'b1; start = 1'b1; cyc(1); start = 1'b0;
    vectors++; if (st !== 2'd1 || digs !== 12'h012) begin miscompares++;
      $display("FAIL start_beats_pause: state %0d digits %h want 1/012", st, digs); end
    cyc(1);
    vectors++; if (st !== 2'd2) begin miscompares++; $display("FAIL pause_after_start: got %0d want 2", st); end
    add = 1'b1; cyc(4);
    vectors++; if (digs !== 12'h052) begin miscompares++; $display("FAIL add_x4: got %h want 052", digs); end
    cyc(1);
    vectors++; if (digs !== 12'h102) begin miscompares++; $display("FAIL add_carry_min: got %h want 102", digs); end
    cyc(1); add = 1'b0;
    vectors++; if (digs !== 12'h112 || warning !== 1'b0) begin miscompares++;
      $display("FAIL add_x6: digits %h warn %b want 112/0", digs, warning); end
    px = 11'd0; py = 11'd0; cyc(1);
    prev = 1'b0;
    for (int i = 0; i < 13; i++) begin
      px = tab[i].x; py = tab[i].y;
      #1;
      vectors++; if (dr !== prev) begin miscompares++;
        $display("FAIL render_latency[%0d]: dr %b before edge want %b", i, dr, prev); end
      @(negedge clk);
      vectors++; if (dr !== tab[i].hit || rgb !== (tab[i].hit ? C_NORM : 8'h00)) begin miscompares++;
        $display("FAIL render[%0d] (%0d,%0d): dr %b rgb %h want %b %h", i, px, py, dr, rgb,
                 tab[i].hit, tab[i].hit ? C_NORM : 8'h00); end
      prev = tab[i].hit;
    end
  endtask

  task automatic test_warn_render();
    pix_t tab[4];
    logic prev;
    tab[0] = '{TX + 11'd2,  TY + 11'd1,  1'b1};
    tab[1] = '{TX + 11'd26, TY + 11'd1,  1'b0};
    tab[2] = '{TX + 11'd44, TY + 11'd1,  1'b1};
    tab[3] = '{TX + 11'd44, TY + 11'd15, 1'b0};
    pause = 1'b0; start = 1'b1; cyc(1); start = 1'b0;
    cyc(20); pause = 1'b1;
    cyc(1);
    vectors++; if (digs !== 12'h010 || st !== 2'd2 || warning !== 1'b1) begin miscompares++;
      $display("FAIL warn_setup: digits %h state %0d warn %b want 010/2/1", digs, st, warning); end
    px = 11'd0; py = 11'd0; cyc(1);
    prev = 1'b0;
    for (int i = 0; i < 4; i++) begin
      px = tab[i].x; py = tab[i].y;
      @(negedge clk);
      vectors++; if (dr !== tab[i].hit || rgb !== (tab[i].hit ? C_WARN : 8'h00)) begin miscompares++;
        $display("FAIL warn_render[%0d]: dr %b rgb %h want %b %h", i, dr, rgb,
                 tab[i].hit, tab[i].hit ? C_WARN : 8'h00); end
      prev = tab[i].hit;
    end
    vectors++; if (prev !== 1'b0 || dr !== 1'b0) begin miscompares++;
      $display("FAIL warn_render_last: dr %b want 0", dr); end
    px = 11'd0; py = 11'd0;
  endtask

  task automatic test_reset_midrun();
    pause = 1'b0; start = 1'b1; cyc(1); start = 1'b0;
    cyc(89);
    vectors++; if (digs !== 12'h004) begin miscompares++; $display("FAIL midrun_0_04: got %h want 004", digs); end
    add = 1'b1; cyc(1); add = 1'b0;
    vectors++; if (digs !== 12'h014) begin miscompares++; $display("FAIL midrun_add_wrap: got %h want 014", digs); end
    reset = 1'b1; cyc(1);
    vectors++; if (digs !== 12'h012 || st !== 2'd0 || expired !== 1'b0 || dr !== 1'b0) begin miscompares++;
      $display("FAIL midrun_reset: digits %h state %0d exp %b dr %b want 012/0/0/0", digs, st, expired, dr); end
    reset = 1'b0; cyc(5);
    vectors++; if (digs !== 12'h012 || st !== 2'd0) begin miscompares++;
      $display("FAIL post_reset_idle: digits %h state %0d want 012/0", digs, st); end
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(1);
    vectors++; if (digs !== 12'h012) begin miscompares++; $display("FAIL pending_dropped: got %h want 012", digs); end
    cyc(9);
    vectors++; if (digs !== 12'h011) begin miscompares++; $display("FAIL post_reset_tick: got %h want 011", digs); end
  endtask

  task automatic test_saturate();
    start2 = 1'b1; cyc(1); start2 = 1'b0; add2 = 1'b1;
    vectors++; if (digs2 !== 12'h959) begin miscompares++; $display("FAIL sat_start: got %h want 959", digs2); end
    cyc(1); add2 = 1'b0;
    vectors++; if (digs2 !== 12'h959) begin miscompares++; $display("FAIL sat_959_add: got %h want 959", digs2); end
    cyc(39);
    vectors++; if (digs2 !== 12'h955 || warning2 !== 1'b0) begin miscompares++;
      $display("FAIL sat_reach_955: digits %h warn %b want 955/0", digs2, warning2); end
    add2 = 1'b1; cyc(1); add2 = 1'b0;
    vectors++; if (digs2 !== 12'h959) begin miscompares++; $display("FAIL sat_955_add: got %h want 959", digs2); end
    cyc(9);
    vectors++; if (digs2 !== 12'h958) begin miscompares++; $display("FAIL sat_next_tick: got %h want 958", digs2); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_add_tick();
    test_render();
    test_warn_render();
    test_reset_midrun();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
